// File: rtl/lram_pkg.sv
// Shared types and default geometry for the LRAM arbiter and its RAM.
package lram_pkg;

    localparam int unsigned LRAM_ADDR_W = 10;
    localparam int unsigned LRAM_DATA_W = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lram_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_sel_e;

endpackage

// File: rtl/lram_sp.sv
// Single-port synchronous RAM mapped onto LRAM; registered read, one cycle latency.
module lram_sp
    import lram_pkg::*;
#(
    parameter int unsigned ADDR_W = LRAM_ADDR_W,
    parameter int unsigned DATA_W = LRAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    (* ram_style = "huge" *) logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/lram_arbiter.sv
// Clears the LRAM after reset, then round-robins one access per cycle between A and B.
// Read data 1 cycle after grant; ready is combinational and never high during the clear.
module lram_arbiter
    import lram_pkg::*;
#(
    parameter int unsigned ADDR_W         = LRAM_ADDR_W,
    parameter int unsigned DATA_W         = LRAM_DATA_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              gsrn_i,

    input  logic              a_valid_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ready_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,

    input  logic              b_valid_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ready_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o,

    output logic              init_done_o
);

    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    lram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    req_sel_e          ptr_q, ptr_d;
    logic              init_done_q, init_done_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_hold_q, b_hold_q;

    logic              run;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Reset qualifies grants so a no-clear build still shows ready=0 while held in reset.
    assign run       = (state_q == ST_RUN) && gsrn_i;
    assign a_ready_o = run && a_valid_i && (!b_valid_i || (ptr_q == REQ_A));
    assign b_ready_o = run && b_valid_i && (!a_valid_i || (ptr_q == REQ_B));

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        unique case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (a_ready_o) begin
                    ram_we    = a_we_i;
                    ram_addr  = a_addr_i;
                    ram_wdata = a_wdata_i;
                    ptr_d     = REQ_B;
                end else if (b_ready_o) begin
                    ram_we    = b_we_i;
                    ram_addr  = b_addr_i;
                    ram_wdata = b_wdata_i;
                    ptr_d     = REQ_A;
                end
            end
            default: ;
        endcase
    end

    assign a_rvalid_d = a_ready_o && !a_we_i;
    assign b_rvalid_d = b_ready_o && !b_we_i;

    always_ff @(posedge clk_i or negedge gsrn_i) begin
        if (!gsrn_i) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            ptr_q       <= REQ_A;
            init_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_hold_q    <= '0;
            b_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_hold_q    <= a_rdata_o;
            b_hold_q    <= b_rdata_o;
        end
    end

    // RAM output register is the read-data stage; the hold register keeps the last value per port.
    assign a_rdata_o   = a_rvalid_q ? ram_rdata : a_hold_q;
    assign b_rdata_o   = b_rvalid_q ? ram_rdata : b_hold_q;
    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    assign init_done_o = init_done_q;

    lram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_lram_arbiter.sv
// Directed bench for lram_arbiter: clear, single access, contention, coherency, resets.
module tb_lram_arbiter;

    logic        clk_i = 1'b0;
    logic        gsrn_i;
    logic        a_valid_i, a_we_i, b_valid_i, b_we_i;
    logic [9:0]  a_addr_i, b_addr_i;
    logic [15:0] a_wdata_i, b_wdata_i;
    logic        a_ready_o, a_rvalid_o, b_ready_o, b_rvalid_o, init_done_o;
    logic [15:0] a_rdata_o, b_rdata_o;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    lram_arbiter dut (
        .clk_i       (clk_i),
        .gsrn_i      (gsrn_i),
        .a_valid_i   (a_valid_i),
        .a_we_i      (a_we_i),
        .a_addr_i    (a_addr_i),
        .a_wdata_i   (a_wdata_i),
        .a_ready_o   (a_ready_o),
        .a_rvalid_o  (a_rvalid_o),
        .a_rdata_o   (a_rdata_o),
        .b_valid_i   (b_valid_i),
        .b_we_i      (b_we_i),
        .b_addr_i    (b_addr_i),
        .b_wdata_i   (b_wdata_i),
        .b_ready_o   (b_ready_o),
        .b_rvalid_o  (b_rvalid_o),
        .b_rdata_o   (b_rdata_o),
        .init_done_o (init_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called right after reset release: expects exactly 1024 clear cycles with no grants.
    task automatic clear_phase(input string tag);
        int bad = 0;
        a_valid_i = 1'b1; a_we_i = 1'b0;
        b_valid_i = 1'b1; b_we_i = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            if (init_done_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) bad++;
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        chk({tag, "_busy"}, 32'(bad), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(init_done_o), 32'd1);
    endtask

    initial begin
        gsrn_i    = 1'b0;
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
        b_valid_i = 1'b1; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
        tick();
        tick();
        chk("rst_ready", 32'({a_ready_o, b_ready_o}), 32'd0);
        chk("rst_rvalid", 32'({a_rvalid_o, b_rvalid_o, init_done_o}), 32'd0);
        chk("rst_rdata", {a_rdata_o, b_rdata_o}, 32'd0);

        gsrn_i = 1'b1;
        clear_phase("clear1");

        // Read of the last address after the clear.
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h3FF;
        #1;
        chk("rd3ff_grant", 32'({a_ready_o, b_ready_o}), 32'b10);
        tick();
        a_valid_i = 1'b0;
        chk("rd3ff_rvalid", 32'({a_rvalid_o, b_rvalid_o}), 32'b10);
        chk("rd3ff_rdata", 32'(a_rdata_o), 32'h0000);
        tick();
        chk("rd3ff_pulse", 32'(a_rvalid_o), 32'd0);

        // Write 0xBEEF to 0x005, then read it back the next cycle.
        a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = 10'h005; a_wdata_i = 16'hBEEF;
        #1;
        chk("wr5_grant", 32'(a_ready_o), 32'd1);
        tick();
        a_we_i = 1'b0;
        #1;
        chk("rd5_grant", 32'(a_ready_o), 32'd1);
        chk("wr5_noresp", 32'(a_rvalid_o), 32'd0);
        tick();
        a_valid_i = 1'b0;
        chk("rd5_rvalid", 32'({a_rvalid_o, b_rvalid_o}), 32'b10);
        chk("rd5_rdata", 32'(a_rdata_o), 32'hBEEF);
        tick();
        chk("rd5_pulse", 32'(a_rvalid_o), 32'd0);

        // B writes 0x2222 to 0x020 alone, leaving the pointer on A.
        b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 10'h020; b_wdata_i = 16'h2222;
        #1;
        chk("wr20_grant", 32'({a_ready_o, b_ready_o}), 32'b01);
        tick();
        b_we_i = 1'b0;
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h005;

        // Both read continuously for 4 cycles: grants alternate A, B, A, B.
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_grant", k), 32'({a_ready_o, b_ready_o}),
                (k % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            if (k == 3) begin
                a_valid_i = 1'b0;
                b_valid_i = 1'b0;
            end
            if (k % 2 == 0) begin
                chk($sformatf("cont%0d_rv", k), 32'({a_rvalid_o, b_rvalid_o}), 32'b10);
                chk($sformatf("cont%0d_ad", k), 32'(a_rdata_o), 32'hBEEF);
            end else begin
                chk($sformatf("cont%0d_rv", k), 32'({a_rvalid_o, b_rvalid_o}), 32'b01);
                chk($sformatf("cont%0d_bd", k), 32'(b_rdata_o), 32'h2222);
                chk($sformatf("cont%0d_ahold", k), 32'(a_rdata_o), 32'hBEEF);
            end
        end

        // A reads 0x200 while B wants to write it; pointer is on A.
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h200;
        b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 10'h200; b_wdata_i = 16'h1234;
        #1;
        chk("coh_grant_a", 32'({a_ready_o, b_ready_o}), 32'b10);
        tick();
        a_valid_i = 1'b0;
        #1;
        chk("coh_grant_b", 32'({a_ready_o, b_ready_o}), 32'b01);
        chk("coh_old_rv", 32'(a_rvalid_o), 32'd1);
        chk("coh_old_data", 32'(a_rdata_o), 32'h0000);
        tick();
        b_valid_i = 1'b0;
        a_valid_i = 1'b1;
        #1;
        chk("coh_rd2_grant", 32'(a_ready_o), 32'd1);
        tick();
        a_valid_i = 1'b0;
        chk("coh_new_rv", 32'(a_rvalid_o), 32'd1);
        chk("coh_new_data", 32'(a_rdata_o), 32'h1234);

        // Pre-write 0x1F0 and confirm it stuck.
        a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = 10'h1F0; a_wdata_i = 16'hA5A5;
        tick();
        a_we_i = 1'b0;
        tick();
        a_valid_i = 1'b0;
        chk("pre1f0_data", 32'(a_rdata_o), 32'hA5A5);
        tick();

        // Reset asserted in the cycle after a read grant.
        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h005;
        #1;
        chk("fly_grant", 32'(a_ready_o), 32'd1);
        tick();
        gsrn_i = 1'b0;
        b_valid_i = 1'b1;
        #1;
        chk("fly_rvalid", 32'({a_rvalid_o, b_rvalid_o}), 32'd0);
        chk("fly_rdata", {a_rdata_o, b_rdata_o}, 32'd0);
        chk("fly_ctrl", 32'({a_ready_o, b_ready_o, init_done_o}), 32'd0);
        tick();
        chk("fly_rvalid2", 32'(a_rvalid_o), 32'd0);

        // Release, abort the clear at cycle 500, then require a full clear.
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        gsrn_i = 1'b1;
        repeat (500) tick();
        chk("mid_notdone", 32'(init_done_o), 32'd0);
        gsrn_i = 1'b0;
        #1;
        chk("mid_rst_done", 32'(init_done_o), 32'd0);
        tick();
        gsrn_i = 1'b1;
        clear_phase("clear2");

        a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h1F0;
        #1;
        chk("post1f0_grant", 32'(a_ready_o), 32'd1);
        tick();
        a_addr_i = 10'h005;
        chk("post1f0_rv", 32'(a_rvalid_o), 32'd1);
        chk("post1f0_data", 32'(a_rdata_o), 32'h0000);
        tick();
        a_valid_i = 1'b0;
        chk("post005_data", 32'(a_rdata_o), 32'h0000);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
